// File: rtl/pulse_sync_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sync_pkg
// Purpose  : Shared definitions for the req/ack pulse synchronizer slice.
//            Holds the responder FSM state encoding and default parameters.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pulse_sync_pkg;

    // Responder FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_DEF     = 16;

endpackage : pulse_sync_pkg
`default_nettype wire

// File: rtl/pulse_sync_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sync_rx_if
// Purpose  : Event hand-off bus between the pulse responder and its consumer.
// Ports    : evt_valid  event pending (producer -> consumer)
//            evt_ready  consumer accepts event (consumer -> producer)
//            evt_cnt    running count of accepted events (producer -> consumer)
// Revision : 1.0  initial release
// ============================================================================
interface pulse_sync_rx_if #(
    parameter int CNT_W = 8
);
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_cnt;

    // Producer side (the responder)
    modport master (
        output evt_valid,
        output evt_cnt,
        input  evt_ready
    );

    // Consumer side
    modport slave (
        input  evt_valid,
        input  evt_cnt,
        output evt_ready
    );
endinterface : pulse_sync_rx_if
`default_nettype wire

// File: rtl/pulse_sync_rx_sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Purpose  : N-stage flop-chain synchronizer with asynchronous active-low
//            reset. Used for req_async here and for ack_s on the initiator.
// Ports    : clk    destination clock
//            rst_n  asynchronous active-low reset (chain clears to 0)
//            i_d    asynchronous input level
//            o_q    synchronized level, STAGES edges after sampling
// Revision : 1.0  initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);
    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];
endmodule : sync_ff
`default_nettype wire

// File: rtl/pulse_sync_rx.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sync_rx
// Purpose  : clk_s-side responder of a four-phase req/ack pulse handshake.
//            Synchronizes req_async, presents one event per request on a
//            valid/ready bus, returns a registered ack once the event is
//            taken, counts accepted events and flags stuck requests.
// Ports    : clk_s        destination clock
//            rst_n        asynchronous active-low reset
//            req_async    request level from the initiator domain
//            ack_s        registered acknowledge level to the initiator
//            timeout_err  sticky stuck-request flag
//            err_clr      clears timeout_err (a simultaneous set wins)
//            evt          event bus (valid/ready/count), master side
// Revision : 1.0  initial release
// ============================================================================
module pulse_sync_rx
    import pulse_sync_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  wire logic         clk_s,
    input  wire logic         rst_n,
    input  wire logic         req_async,
    output logic              ack_s,
    output logic              timeout_err,
    input  wire logic         err_clr,
    pulse_sync_rx_if.master   evt
);
    localparam logic [1:0] c_ST_IDLE  = ST_IDLE;
    localparam logic [1:0] c_ST_VALID = ST_VALID;
    localparam logic [1:0] c_ST_ACK   = ST_ACK;

    logic             w_req_sync;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_accept;
    logic             r_evt_valid;
    logic             r_ack;
    logic [CNT_W-1:0] r_evt_cnt;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk_s),
        .rst_n (rst_n),
        .i_d   (req_async),
        .o_q   (w_req_sync)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req_sync) begin
                    w_state_nxt = c_ST_VALID;
                end
            end
            c_ST_VALID: begin
                // A request that drops here is still delivered; ACK then
                // exits after one cycle because req_sync is already low.
                if (evt.evt_ready) begin
                    w_state_nxt = c_ST_ACK;
                    w_accept    = 1'b1;
                end
            end
            c_ST_ACK: begin
                if (!w_req_sync) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so evt_valid
    // and ack_s are flop outputs that track the state register exactly.
    always_ff @(posedge clk_s or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_evt_valid <= 1'b0;
            r_ack       <= 1'b0;
            r_evt_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_evt_valid <= (w_state_nxt == c_ST_VALID);
            r_ack       <= (w_state_nxt == c_ST_ACK);
            if (w_accept) begin
                r_evt_cnt <= r_evt_cnt + 1'b1;
            end
        end
    end

    assign evt.evt_valid = r_evt_valid;
    assign evt.evt_cnt   = r_evt_cnt;
    assign ack_s         = r_ack;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int              c_TO_W   = $clog2(TIMEOUT + 1);
            localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT);

            logic [c_TO_W-1:0] r_to_cnt;
            logic              r_err;
            logic              w_stuck;
            logic              w_to_hit;

            assign w_stuck  = (r_state == c_ST_ACK) && w_req_sync;
            // Fires on the edge that completes the TIMEOUT-th stuck cycle.
            assign w_to_hit = w_stuck && (r_to_cnt == c_TO_MAX - 1'b1);

            always_ff @(posedge clk_s or negedge rst_n) begin
                if (!rst_n) begin
                    r_to_cnt <= '0;
                    r_err    <= 1'b0;
                end else begin
                    if (!w_stuck) begin
                        r_to_cnt <= '0;
                    end else if (r_to_cnt != c_TO_MAX) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                    if (w_to_hit) begin
                        r_err <= 1'b1;
                    end else if (err_clr) begin
                        r_err <= 1'b0;
                    end
                end
            end

            assign timeout_err = r_err;
        end else begin : g_no_timeout
            assign timeout_err = 1'b0;
        end
    endgenerate
endmodule : pulse_sync_rx
`default_nettype wire

// File: tb/tb_pulse_sync_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_sync_rx
// Purpose  : Self-checking bench for pulse_sync_rx (SYNC_STAGES=2, CNT_W=8,
//            TIMEOUT=16). Expected evt_cnt per transfer is queued with each
//            request; a monitor pops and compares on every valid&ready.
// Revision : 1.0  initial release
// ============================================================================
module tb_pulse_sync_rx;
    localparam int CNT_W = 8;

    logic clk_s     = 1'b0;
    logic rst_n     = 1'b0;
    logic req_async = 1'b0;
    logic err_clr   = 1'b0;
    logic ack_s;
    logic timeout_err;

    pulse_sync_rx_if #(.CNT_W(CNT_W)) bus ();

    pulse_sync_rx #(
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W),
        .TIMEOUT     (16)
    ) dut (
        .clk_s       (clk_s),
        .rst_n       (rst_n),
        .req_async   (req_async),
        .ack_s       (ack_s),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .evt         (bus.master)
    );

    always #5 clk_s = ~clk_s;

    int               n_checks = 0;
    int               n_errors = 0;
    int               n_xfers  = 0;
    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] model_cnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_evt();
        exp_q.push_back(model_cnt);
        model_cnt = model_cnt + 1'b1;
    endtask

    // Full handshake with a ready consumer; waits are bounded.
    task automatic do_req();
        int k;
        expect_evt();
        req_async = 1'b1;
        k = 0;
        while (ack_s !== 1'b1 && k < 20) begin tick(); k++; end
        chk("ack_rise", ack_s, 1);
        req_async = 1'b0;
        k = 0;
        while (ack_s !== 1'b0 && k < 20) begin tick(); k++; end
        chk("ack_fall", ack_s, 0);
    endtask

    // Scoreboard monitor
    initial begin
        logic [CNT_W-1:0] e;
        forever begin
            @(negedge clk_s);
            if (rst_n === 1'b1 && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
                n_xfers++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_event: got transfer with evt_cnt=%0d, none expected", bus.evt_cnt);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_evt_cnt", bus.evt_cnt, e);
                end
            end
        end
    end

    initial begin
        bus.evt_ready = 1'b1;
        ticks(3);
        chk("rst_ack", ack_s, 0);
        chk("rst_valid", bus.evt_valid, 0);
        chk("rst_cnt", bus.evt_cnt, 0);
        chk("rst_err", timeout_err, 0);
        rst_n = 1'b1;
        tick();

        // 256 back-to-back handshakes: counter wraps to 0
        for (int i = 0; i < 256; i++) do_req();
        chk("wrap_cnt", bus.evt_cnt, 0);
        chk("wrap_xfers", n_xfers, 256);

        // Single request, zero-wait consumer, exact latencies
        expect_evt();
        req_async = 1'b1;
        tick();                                   // E
        chk("t1_valid_E", bus.evt_valid, 0);
        tick();                                   // E+1
        chk("t1_valid_E1", bus.evt_valid, 0);
        tick();                                   // E+2
        chk("t1_valid_E2", bus.evt_valid, 1);
        chk("t1_ack_E2", ack_s, 0);
        tick();                                   // E+3
        chk("t1_valid_E3", bus.evt_valid, 0);
        chk("t1_ack_E3", ack_s, 1);
        chk("t1_cnt", bus.evt_cnt, 1);
        req_async = 1'b0;
        tick();                                   // F
        chk("t1_ack_F", ack_s, 1);
        tick();                                   // F+1
        chk("t1_ack_F1", ack_s, 1);
        tick();                                   // F+2
        chk("t1_ack_F2", ack_s, 0);

        // Backpressure: ready low for 10 cycles
        bus.evt_ready = 1'b0;
        req_async = 1'b1;
        ticks(3);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_held", bus.evt_valid, 1);
            chk("bp_ack_low", ack_s, 0);
            chk("bp_cnt_same", bus.evt_cnt, 1);
            tick();
        end
        expect_evt();
        bus.evt_ready = 1'b1;
        tick();
        chk("bp_ack", ack_s, 1);
        chk("bp_valid_drop", bus.evt_valid, 0);
        chk("bp_cnt", bus.evt_cnt, 2);
        req_async = 1'b0;
        ticks(3);
        chk("bp_ack_fall", ack_s, 0);

        // Stuck request in ACK: timeout on the 16th stuck cycle
        expect_evt();
        req_async = 1'b1;
        ticks(4);
        chk("to_ack", ack_s, 1);
        chk("to_cnt", bus.evt_cnt, 3);
        ticks(15);
        chk("to_err_15", timeout_err, 0);
        tick();
        chk("to_err_16", timeout_err, 1);
        ticks(4);
        chk("to_ack_held", ack_s, 1);
        chk("to_err_20", timeout_err, 1);
        req_async = 1'b0;
        ticks(3);
        chk("to_ack_fall", ack_s, 0);
        chk("to_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_err_clr", timeout_err, 0);

        // Request dropped before acceptance: still one event, 1-cycle ack
        bus.evt_ready = 1'b0;
        req_async = 1'b1;
        ticks(3);
        chk("vio_valid", bus.evt_valid, 1);
        req_async = 1'b0;
        ticks(3);
        chk("vio_valid_kept", bus.evt_valid, 1);
        chk("vio_ack_low", ack_s, 0);
        expect_evt();
        bus.evt_ready = 1'b1;
        tick();
        chk("vio_ack_1", ack_s, 1);
        chk("vio_cnt", bus.evt_cnt, 4);
        tick();
        chk("vio_ack_2", ack_s, 0);
        chk("vio_valid_2", bus.evt_valid, 0);

        // Reset while in VALID: outputs clear at once, event discarded
        bus.evt_ready = 1'b0;
        req_async = 1'b1;
        ticks(3);
        chk("rv_valid", bus.evt_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rv_valid_async", bus.evt_valid, 0);
        chk("rv_ack_async", ack_s, 0);
        chk("rv_cnt_async", bus.evt_cnt, 0);
        model_cnt = '0;
        req_async = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rv_no_event", bus.evt_valid, 0);
        end
        chk("rv_ack_idle", ack_s, 0);
        do_req();
        chk("rv_cnt_after", bus.evt_cnt, 1);

        ticks(2);
        chk("q_empty", exp_q.size(), 0);
        chk("xfer_total", n_xfers, 261);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule : tb_pulse_sync_rx
`default_nettype wire

// File: doc/pulse_sync_rx.md
# pulse_sync_rx

Destination-side responder of the four-phase req/ack pulse handshake between a fast initiator domain and the slow `clk_s` domain. Synchronizes the asynchronous request level, presents exactly one event per request on a valid/ready interface, returns a registered acknowledge once the event is consumed, and keeps a wrap-around event count plus a sticky stuck-request flag. It sits at the `clk_s` end of fast-to-slow pulse transfer; the initiator holds `req_async` until it sees `ack_s`.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `req_async`; legal values are 2 or more.
- `CNT_W`, 8: width of the event counter.
- `TIMEOUT`, 16: maximum number of `clk_s` cycles that `req_async` may stay high while in ACK; 0 disables the check.

- `clk_s`  in  1  destination clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_async`  in  1  request level from initiator domain, not synchronous to `clk_s`
- `ack_s`  out  1  registered acknowledge level, returned to initiator domain
- `evt_valid`  out  1  one captured event pending
- `evt_ready`  in  1  consumer accepts event
- `evt_cnt`  out  CNT_W  accepted-event count
- `timeout_err`  out  1  sticky stuck-request flag
- `err_clr`  in  1  clears `timeout_err`

## Operation
- `req_async` passes through a `SYNC_STAGES` flop chain to give `req_sync`. No other logic samples `req_async`.
- FSM states:
  - IDLE: if `req_sync`=1, go to VALID.
  - VALID: if `evt_ready`=1, go to ACK and increment `evt_cnt`.
  - ACK: if `req_sync`=0, go to IDLE.
- `evt_valid` = (state==VALID). `ack_s` = (state==ACK). Both come directly from state flops, with no combinational path to outputs.
- `evt_valid` is held until it is accepted. `evt_ready` is ignored outside VALID.
- `evt_cnt` is CNT_W-bit unsigned and wraps from 2^CNT_W−1 to 0.
- Exactly one event is produced per request high phase. A request that is still high after returning to IDLE cannot occur, because ACK exits only when `req_sync`=0.
- Protocol violation (request drops while in VALID): the event is kept. After acceptance, ACK lasts exactly 1 cycle because `req_sync` is already 0.
- Timeout:
  - A counter runs while in ACK with `req_sync`=1, and clears on leaving ACK.
  - On reaching TIMEOUT, it sets `timeout_err`. The state stays in ACK and the counter saturates.
  - `err_clr` clears the flag. If a set and a clear happen in the same cycle, the set wins.
- Reset values: `ack_s`=0, `evt_valid`=0, `evt_cnt`=0, `timeout_err`=0, state IDLE, synchronizer flops 0, timeout counter 0.
- Reset mid-operation clears everything asynchronously. `ack_s` falls immediately, and any pending event is discarded and not counted.

## Timing
- Let edge E be the first `clk_s` edge that samples `req_async`=1 into sync stage 1.
- `req_sync` is high after edge E+SYNC_STAGES−1.
- `evt_valid` goes high after edge E+SYNC_STAGES (3 edges after sampling with the default depth).
- Acceptance edge A (`evt_valid`&`evt_ready`):
  - after A: `ack_s`=1, `evt_valid`=0, `evt_cnt`+1.
  - Zero-wait consumer: `ack_s` rises 1 edge after `evt_valid`.
- `req_async` falls at edge F: `ack_s` falls after edge F+SYNC_STAGES.
- Full cycle with default depth and an immediately ready consumer: ack rises 4 `clk_s` edges after the request is sampled, and falls 3 edges after the fall is sampled.
- `timeout_err` rises on the TIMEOUT-th consecutive ACK cycle with `req_sync`=1.

## Structure
- Shared package `pulse_sync_pkg`:
  - state enum (IDLE, VALID, ACK)
  - default constants SYNC_STAGES_DEF=2, TIMEOUT_DEF=16
- One sub-module, `sync_ff`: a parameterized N-stage async-reset synchronizer. It is reused by the initiator side for `ack_s`.
- The FSM, counters and flags live in `pulse_sync_rx`.

## Test plan
- Single request, `evt_ready` tied 1, `req_async` high until ack seen → one `evt_valid` cycle, `ack_s` high, `evt_cnt`=1, `ack_s` low 3 edges after req fall.
- Backpressure: `evt_ready`=0 for 10 cycles → `evt_valid` held 10+ cycles, `ack_s`=0, `evt_cnt` unchanged; accepted on first ready cycle.
- 256 back-to-back handshakes with CNT_W=8 → `evt_cnt` wraps to 0, exactly 256 valid/ready transfers.
- Request held high 20 cycles in ACK, TIMEOUT=16 → `timeout_err`=1 at 16th cycle, stays 1 after req drops; `err_clr` pulse → 0.
- Reset asserted while in VALID → `evt_valid`, `ack_s` 0 immediately, `evt_cnt`=0; after release with req low, state IDLE and no spurious event.
- Request pulse dropped before ack (violation) → event still delivered once, `ack_s` high exactly 1 cycle.
